serial_magcom: RTL and testbench

Multi-bit magnitude comparator that sits directly downstream of the 1-bit `magcom` cell and consumes its `l`/`e`/`g` outputs. It latches two WIDTH-bit operands on a start/ready handshake. It then walks them MSB-first, one bit per clock, through a single `magcom` instance, stopping at the first differing bit. It reports a one-hot less/equal/greater result plus the index of the deciding bit.

---
 rtl/magcom_pkg.sv | 25 ++
 rtl/magcom.sv | 14 +
 rtl/serial_magcom.sv | 119 +++++++++++
 tb/tb_serial_magcom.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/magcom_pkg.sv
// Shared types and result encoding for the bit-serial magnitude comparator.
package magcom_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } magcom_state_t;

    // One-hot {lt, eq, gt} result encoding
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_LT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_GT   = 3'b001;

    function automatic logic [2:0] res_encode(input logic l, input logic g);
        if (l) begin
            return RES_LT;
        end else if (g) begin
            return RES_GT;
        end
        return RES_EQ;
    endfunction

endpackage

// File: rtl/magcom.sv
// 1-bit magnitude comparator cell: one-hot less/equal/greater of a vs b.
module magcom (
    input  logic a,
    input  logic b,
    output logic l,
    output logic e,
    output logic g
);

    assign l = ~a & b;
    assign e = ~(a ^ b);
    assign g = a & ~b;

endmodule

// File: rtl/serial_magcom.sv
// Bit-serial unsigned magnitude comparator: walks latched operands MSB-first
// through one magcom slice and stops at the first differing bit.
module serial_magcom
    import magcom_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic [IDXW-1:0]  diff_pos
);

    magcom_state_t    state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [2:0]       res_q, res_d;
    logic [IDXW-1:0]  diff_pos_q, diff_pos_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;

    logic bit_l;
    logic bit_e;
    logic bit_g;

    magcom u_slice (
        .a (a_q[idx_q]),
        .b (b_q[idx_q]),
        .l (bit_l),
        .e (bit_e),
        .g (bit_g)
    );

    // Next-state, datapath and output decode
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        idx_d      = idx_q;
        res_d      = res_q;
        diff_pos_d = diff_pos_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d        = a;
                    b_d        = b;
                    idx_d      = IDXW'(WIDTH - 1);
                    res_d      = RES_NONE;
                    diff_pos_d = '0;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (!bit_e) begin
                    res_d      = res_encode(bit_l, bit_g);
                    diff_pos_d = idx_q;
                    done_d     = 1'b1;
                    state_d    = DONE;
                end else if (idx_q == '0) begin
                    res_d      = RES_EQ;
                    diff_pos_d = '0;
                    done_d     = 1'b1;
                    state_d    = DONE;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            idx_q      <= '0;
            res_q      <= RES_NONE;
            diff_pos_q <= '0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            idx_q      <= idx_d;
            res_q      <= res_d;
            diff_pos_q <= diff_pos_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign lt       = res_q[2];
    assign eq       = res_q[1];
    assign gt       = res_q[0];
    assign diff_pos = diff_pos_q;

endmodule

// File: tb/tb_serial_magcom.sv
// Directed self-checking bench for serial_magcom (WIDTH=8).
module tb_serial_magcom;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned IDXW  = $clog2(WIDTH);

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic             lt;
    logic             eq;
    logic             gt;
    logic [IDXW-1:0]  diff_pos;

    int checks = 0;
    int errors = 0;

    serial_magcom #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .done     (done),
        .lt       (lt),
        .eq       (eq),
        .gt       (gt),
        .diff_pos (diff_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one compare; n counts cycles after the accepting edge (n=1 is T+1).
    // With inject set, a stray start with new operands is driven during SCAN.
    task automatic run(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input int m, input logic [2:0] res, input logic [IDXW-1:0] pos,
                       input bit inject);
        int n;
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        check({tag, "_busy"}, 32'(ready), 32'd0);
        check({tag, "_clr"}, 32'({lt, eq, gt}), 32'd0);
        while (!done && n <= int'(WIDTH) + 4) begin
            if (inject && n == 2) begin
                start = 1'b1;
                a = 8'h00;
                b = 8'hFF;
            end
            if (inject && n == 3) begin
                start = 1'b0;
                a = 8'h11;
                b = 8'hEE;
            end
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(m + 1));
        check({tag, "_res"}, 32'({lt, eq, gt}), 32'(res));
        check({tag, "_pos"}, 32'(diff_pos), 32'(pos));
        @(negedge clk);
        check({tag, "_done1"}, 32'(done), 32'd0);
        check({tag, "_rdy"}, 32'(ready), 32'd1);
        check({tag, "_hold"}, 32'({lt, eq, gt, diff_pos}), 32'({res, pos}));
    endtask

    initial begin
        int saw_done;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res", 32'({lt, eq, gt}), 32'd0);
        check("rst_pos", 32'(diff_pos), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(ready), 32'd1);

        run("msb", 8'h80, 8'h00, 1, 3'b001, 3'd7, 1'b0);
        run("lsb", 8'h54, 8'h55, 8, 3'b100, 3'd0, 1'b0);
        run("eq",  8'hA5, 8'hA5, 8, 3'b010, 3'd0, 1'b0);
        repeat (3) @(negedge clk);
        check("eq_hold_late", 32'({lt, eq, gt}), 32'b010);
        // Bits 7..3 are examined; bit 3 decides A > B.
        run("ign", 8'h3C, 8'h30, 5, 3'b001, 3'd3, 1'b1);
        run("mid", 8'h12, 8'h1A, 5, 3'b100, 3'd3, 1'b0);

        // Abort an in-flight compare with an asynchronous reset
        @(negedge clk);
        a = 8'h00;
        b = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_res", 32'({lt, eq, gt, diff_pos}), 32'd0);
        saw_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1;
        end
        check("abort_nodone", 32'(saw_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        check("abort_nodone_post", 32'(saw_done), 32'd0);
        run("post", 8'h01, 8'h02, 7, 3'b100, 3'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
